tdm_demux4: RTL and testbench

- Receive-side partner of the 4:1 channel mux: a 1-to-4 time-division demultiplexer/deframer.
- Accepts a serial stream of WIDTH-bit slots, one slot per valid beat. Slot 0 of every frame is marked by `sync`.
- Locks onto the frame and distributes slots to four registered channel outputs a/b/c/d using the mux select encoding {s1,s0} = 00→a, 01→b, 10→c, 11→d.
- Presents each complete frame atomically, with a one-cycle `frame_valid` strobe.

---
 rtl/tdm_demux4_if.sv | 32 +++
 rtl/tdm_demux4.sv | 194 +++++++++++++++++++
 tb/tb_tdm_demux4.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_demux4_if.sv
// Slot stream and channel outputs of the 1-to-4 TDM demultiplexer.
//   in_valid/din/sync : incoming slot stream (master drives, slave receives)
//   ch_a..ch_d        : per-channel outputs, slots 0..3 of the last good frame
//   frame_valid       : one-cycle strobe when ch_a..ch_d update
//   locked            : deframer is locked to the frame
//   sync_err          : one-cycle strobe on a sync anomaly while locked
//   parity_err        : one-cycle strobe on a parity-word mismatch
interface tdm_demux4_if #(
    parameter int unsigned WIDTH = 1
);
    logic             in_valid;
    logic [WIDTH-1:0] din;
    logic             sync;
    logic [WIDTH-1:0] ch_a;
    logic [WIDTH-1:0] ch_b;
    logic [WIDTH-1:0] ch_c;
    logic [WIDTH-1:0] ch_d;
    logic             frame_valid;
    logic             locked;
    logic             sync_err;
    logic             parity_err;

    modport master (
        output in_valid, din, sync,
        input  ch_a, ch_b, ch_c, ch_d, frame_valid, locked, sync_err, parity_err
    );

    modport slave (
        input  in_valid, din, sync,
        output ch_a, ch_b, ch_c, ch_d, frame_valid, locked, sync_err, parity_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// 1-to-4 time-division demultiplexer / deframer.
// Locks onto slot 0 (marked by sync), collects one frame into shadow registers
// and presents it atomically on ch_a..ch_d with a one-cycle frame_valid.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : tdm_demux4_if.slave (slot stream in, channels and status out)
// Parameters: WIDTH (bits per slot), MISS_LIMIT (1..7 missed slot-0 syncs
// tolerated before lock is dropped).
// Optional macro TDM_PARITY_EN: 5-slot frames whose slot 4 is the XOR parity
// of slots 0..3; a frame is delivered only when its parity word matches.
module tdm_demux4 #(
    parameter int unsigned WIDTH      = 1,
    parameter int unsigned MISS_LIMIT = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    tdm_demux4_if.slave   bus
);

    localparam logic [0:0] ST_HUNT   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

`ifdef TDM_PARITY_EN
    localparam int unsigned SLOT_W = 3;
`else
    localparam int unsigned SLOT_W = 2;
`endif
    localparam int unsigned MISS_W = 3;

    logic [0:0]        r_state,  w_state;
    logic [SLOT_W-1:0] r_slot,   w_slot;
    logic [MISS_W-1:0] r_miss,   w_miss;
    logic [WIDTH-1:0]  r_sh0,    w_sh0;
    logic [WIDTH-1:0]  r_sh1,    w_sh1;
    logic [WIDTH-1:0]  r_sh2,    w_sh2;
    logic [WIDTH-1:0]  r_ch_a,   w_ch_a;
    logic [WIDTH-1:0]  r_ch_b,   w_ch_b;
    logic [WIDTH-1:0]  r_ch_c,   w_ch_c;
    logic [WIDTH-1:0]  r_ch_d,   w_ch_d;
    logic              r_frame_valid, w_frame_valid;
    logic              r_sync_err,    w_sync_err;
`ifdef TDM_PARITY_EN
    logic [WIDTH-1:0]  r_sh3,    w_sh3;
    logic              r_parity_err,  w_parity_err;
    logic [WIDTH-1:0]  w_par;

    assign w_par = r_sh0 ^ r_sh1 ^ r_sh2 ^ r_sh3;
`endif

    // Next-state and next-output decode; idle cycles leave everything unchanged.
    always_comb begin
        w_state       = r_state;
        w_slot        = r_slot;
        w_miss        = r_miss;
        w_sh0         = r_sh0;
        w_sh1         = r_sh1;
        w_sh2         = r_sh2;
        w_ch_a        = r_ch_a;
        w_ch_b        = r_ch_b;
        w_ch_c        = r_ch_c;
        w_ch_d        = r_ch_d;
        w_frame_valid = 1'b0;
        w_sync_err    = 1'b0;
`ifdef TDM_PARITY_EN
        w_sh3         = r_sh3;
        w_parity_err  = 1'b0;
`endif
        if (bus.in_valid) begin
            case (r_state)
                ST_HUNT: begin
                    if (bus.sync) begin
                        w_sh0   = bus.din;
                        w_slot  = SLOT_W'(1);
                        w_miss  = '0;
                        w_state = ST_LOCKED;
                    end
                end
                default: begin
                    if (r_slot == '0) begin
                        if (bus.sync) begin
                            w_sh0  = bus.din;
                            w_slot = SLOT_W'(1);
                            w_miss = '0;
                        end else begin
                            w_sync_err = 1'b1;
                            if (r_miss + MISS_W'(1) == MISS_W'(MISS_LIMIT)) begin
                                // Too many consecutive misses: drop the frame and re-hunt.
                                w_state = ST_HUNT;
                                w_miss  = '0;
                                w_slot  = '0;
                            end else begin
                                // Flywheel: trust the slot position despite the missing mark.
                                w_miss = r_miss + MISS_W'(1);
                                w_sh0  = bus.din;
                                w_slot = SLOT_W'(1);
                            end
                        end
                    end else if (bus.sync) begin
                        // Early sync restarts the frame; partial frame is discarded.
                        w_sync_err = 1'b1;
                        w_sh0      = bus.din;
                        w_slot     = SLOT_W'(1);
                        w_miss     = '0;
                    end else if (r_slot == SLOT_W'(1)) begin
                        w_sh1  = bus.din;
                        w_slot = SLOT_W'(2);
                    end else if (r_slot == SLOT_W'(2)) begin
                        w_sh2  = bus.din;
                        w_slot = SLOT_W'(3);
`ifdef TDM_PARITY_EN
                    end else if (r_slot == SLOT_W'(3)) begin
                        w_sh3  = bus.din;
                        w_slot = SLOT_W'(4);
                    end else begin
                        w_slot = '0;
                        if (bus.din == w_par) begin
                            w_ch_a        = r_sh0;
                            w_ch_b        = r_sh1;
                            w_ch_c        = r_sh2;
                            w_ch_d        = r_sh3;
                            w_frame_valid = 1'b1;
                        end else begin
                            w_parity_err  = 1'b1;
                        end
                    end
`else
                    end else begin
                        w_slot        = '0;
                        w_ch_a        = r_sh0;
                        w_ch_b        = r_sh1;
                        w_ch_c        = r_sh2;
                        w_ch_d        = bus.din;
                        w_frame_valid = 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= ST_HUNT;
            r_slot        <= '0;
            r_miss        <= '0;
            r_sh0         <= '0;
            r_sh1         <= '0;
            r_sh2         <= '0;
            r_ch_a        <= '0;
            r_ch_b        <= '0;
            r_ch_c        <= '0;
            r_ch_d        <= '0;
            r_frame_valid <= 1'b0;
            r_sync_err    <= 1'b0;
`ifdef TDM_PARITY_EN
            r_sh3         <= '0;
            r_parity_err  <= 1'b0;
`endif
        end else begin
            r_state       <= w_state;
            r_slot        <= w_slot;
            r_miss        <= w_miss;
            r_sh0         <= w_sh0;
            r_sh1         <= w_sh1;
            r_sh2         <= w_sh2;
            r_ch_a        <= w_ch_a;
            r_ch_b        <= w_ch_b;
            r_ch_c        <= w_ch_c;
            r_ch_d        <= w_ch_d;
            r_frame_valid <= w_frame_valid;
            r_sync_err    <= w_sync_err;
`ifdef TDM_PARITY_EN
            r_sh3         <= w_sh3;
            r_parity_err  <= w_parity_err;
`endif
        end
    end

    assign bus.ch_a        = r_ch_a;
    assign bus.ch_b        = r_ch_b;
    assign bus.ch_c        = r_ch_c;
    assign bus.ch_d        = r_ch_d;
    assign bus.frame_valid = r_frame_valid;
    assign bus.locked      = (r_state == ST_LOCKED);
    assign bus.sync_err    = r_sync_err;
`ifdef TDM_PARITY_EN
    assign bus.parity_err  = r_parity_err;
`else
    assign bus.parity_err  = 1'b0;
`endif

endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: expected frames are queued as stimulus is
// driven and popped when frame_valid is seen; pulse counters track sync/parity errors.
module tb_tdm_demux4;
`ifdef TDM_PARITY_EN
    localparam int unsigned W = 4;
`else
    localparam int unsigned W = 1;
`endif

    typedef logic [4*W-1:0] frame_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    tdm_demux4_if #(.WIDTH(W)) bus ();

    tdm_demux4 #(.WIDTH(W), .MISS_LIMIT(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    frame_t sb[$];
    int checks = 0;
    int errors = 0;
    int n_fv   = 0;
    int n_se   = 0;
    int n_pe   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic frame_t outs();
        return {bus.ch_a, bus.ch_b, bus.ch_c, bus.ch_d};
    endfunction

    // Output monitor: counts strobes and checks every delivered frame against the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (bus.sync_err === 1'b1)   n_se++;
            if (bus.parity_err === 1'b1) n_pe++;
            if (bus.frame_valid === 1'b1) begin
                n_fv++;
                chk("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("frame_data", 32'(outs()), 32'(sb.pop_front()));
            end
        end
    end

    task automatic beat(input logic [W-1:0] d, input logic s);
        bus.in_valid = 1'b1;
        bus.din      = d;
        bus.sync     = s;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.din      = '0;
        bus.sync     = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int fv0, se0, pe0;
        bus.in_valid = 1'b0;
        bus.din      = '0;
        bus.sync     = 1'b0;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outs",   32'(outs()), 32'd0);
        chk("reset_locked", 32'(bus.locked), 32'd0);
        chk("reset_fv",     32'(bus.frame_valid), 32'd0);
        chk("reset_se",     32'(bus.sync_err), 32'd0);
        rst_n = 1'b1;
        idle(1);

`ifdef TDM_PARITY_EN
        // Good frame: parity = 3^5^9^6 = 9
        sb.push_back({4'h3, 4'h5, 4'h9, 4'h6});
        fv0 = n_fv; pe0 = n_pe;
        beat(4'h3, 1'b1); beat(4'h5, 1'b0); beat(4'h9, 1'b0); beat(4'h6, 1'b0);
        chk("par_no_fv_before_slot4", 32'(bus.frame_valid), 32'd0);
        beat(4'h9, 1'b0);
        chk("par_fv_pulse", 32'(bus.frame_valid), 32'd1);
        idle(2);
        chk("par_fv_count", 32'(n_fv - fv0), 32'd1);
        chk("par_outs",     32'(outs()), 32'h3596);
        // Bad frame: 1^2^3^4 = 4, parity 0 sent
        fv0 = n_fv;
        beat(4'h1, 1'b1); beat(4'h2, 1'b0); beat(4'h3, 1'b0); beat(4'h4, 1'b0); beat(4'h0, 1'b0);
        chk("par_err_pulse", 32'(bus.parity_err), 32'd1);
        chk("par_bad_no_fv", 32'(bus.frame_valid), 32'd0);
        idle(2);
        chk("par_err_count", 32'(n_pe - pe0), 32'd1);
        chk("par_bad_fv",    32'(n_fv - fv0), 32'd0);
        chk("par_hold_outs", 32'(outs()), 32'h3596);
        chk("par_locked",    32'(bus.locked), 32'd1);
`else
        // Basic frame after reset
        sb.push_back(4'b1011);
        fv0 = n_fv; se0 = n_se;
        beat(1'b1, 1'b1);
        chk("lock_rise", 32'(bus.locked), 32'd1);
        beat(1'b0, 1'b0); beat(1'b1, 1'b0);
        chk("t1_no_fv_early", 32'(bus.frame_valid), 32'd0);
        beat(1'b1, 1'b0);
        chk("t1_fv_pulse", 32'(bus.frame_valid), 32'd1);
        idle(1);
        chk("t1_fv_drop", 32'(bus.frame_valid), 32'd0);
        chk("t1_outs",    32'(outs()), 32'hB);
        chk("t1_fv_cnt",  32'(n_fv - fv0), 32'd1);
        chk("t1_se_cnt",  32'(n_se - se0), 32'd0);

        // Gapped input
        sb.push_back(4'b1011);
        fv0 = n_fv;
        beat(1'b1, 1'b1); idle(3);
        beat(1'b0, 1'b0); idle(3);
        beat(1'b1, 1'b0); idle(3);
        chk("t2_no_fv_gap", 32'(n_fv - fv0), 32'd0);
        beat(1'b1, 1'b0);
        idle(2);
        chk("t2_fv_cnt", 32'(n_fv - fv0), 32'd1);
        chk("t2_outs",   32'(outs()), 32'hB);

        // Early sync on slot 2 restarts the frame
        sb.push_back(4'b1010);
        fv0 = n_fv; se0 = n_se;
        beat(1'b0, 1'b1); beat(1'b1, 1'b0);
        beat(1'b1, 1'b1);
        chk("t3_se_pulse", 32'(bus.sync_err), 32'd1);
        beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
        idle(2);
        chk("t3_se_cnt", 32'(n_se - se0), 32'd1);
        chk("t3_fv_cnt", 32'(n_fv - fv0), 32'd1);
        chk("t3_outs",   32'(outs()), 32'hA);

        // Loss of lock: first miss flywheels, second drops lock
        sb.push_back(4'b1100);
        fv0 = n_fv; se0 = n_se;
        beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0); beat(1'b0, 1'b0);
        chk("t4_flywheel_locked", 32'(bus.locked), 32'd1);
        beat(1'b0, 1'b0);
        chk("t4_unlock", 32'(bus.locked), 32'd0);
        beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
        idle(2);
        chk("t4_se_cnt", 32'(n_se - se0), 32'd2);
        chk("t4_fv_cnt", 32'(n_fv - fv0), 32'd1);
        chk("t4_outs",   32'(outs()), 32'hC);
        sb.push_back(4'b0011);
        beat(1'b0, 1'b1);
        chk("t4_relock", 32'(bus.locked), 32'd1);
        beat(1'b0, 1'b0); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
        idle(2);
        chk("t4_relock_outs", 32'(outs()), 32'h3);

        // Reset mid-frame
        beat(1'b1, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0);
        rst_n = 1'b0;
        idle(1);
        chk("t5_rst_outs",   32'(outs()), 32'd0);
        chk("t5_rst_locked", 32'(bus.locked), 32'd0);
        rst_n = 1'b1;
        sb.push_back(4'b0110);
        fv0 = n_fv;
        beat(1'b0, 1'b1); beat(1'b1, 1'b0); beat(1'b1, 1'b0); beat(1'b0, 1'b0);
        idle(2);
        chk("t5_fv_cnt", 32'(n_fv - fv0), 32'd1);
        chk("t5_outs",   32'(outs()), 32'h6);
        chk("parity_err_idle", 32'(n_pe), 32'd0);
`endif
        idle(3);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
